// File: rtl/ysyx_22040750_dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: strobe encodings, FSM states,
// default DMEM base address and the latched request record.
package ysyx_22040750_dmem_resp_pkg;

    localparam logic [7:0]  STRB_SB = 8'h01;
    localparam logic [7:0]  STRB_SH = 8'h03;
    localparam logic [7:0]  STRB_SW = 8'h0F;
    localparam logic [7:0]  STRB_SD = 8'hFF;

    localparam logic [63:0] DMEM_BASE_DEFAULT = 64'h0000_0000_8000_0000;
    localparam int          NUM_LANES         = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } dmem_op_e;

    typedef struct packed {
        dmem_op_e    op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [8:0]  rstrb;
    } dmem_req_t;

    // Anything other than a legal size mask is handled as a full doubleword.
    function automatic logic [7:0] norm_strb(input logic [7:0] s);
        case (s)
            STRB_SB, STRB_SH, STRB_SW, STRB_SD: norm_strb = s;
            default:                            norm_strb = STRB_SD;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040750_dmem_lane_align.sv
// Byte-lane steering between the 64-bit store word and the right-aligned request:
// write shift/mask and read extract with zero/sign extension. Purely combinational.
module ysyx_22040750_dmem_lane_align
    import ysyx_22040750_dmem_resp_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic [63:0] word,
    input  logic [8:0]  rstrb,
    output logic [63:0] wmask,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata
);

    logic [7:0]  wlane;
    logic [63:0] raw;
    logic [7:0]  top;
    logic [7:0]  msb;
    logic        sign;

    // Shifting inside 8 bits drops lanes that would cross into the next doubleword.
    assign wlane    = wstrb << off;
    assign wdata_sh = wdata << {off, 3'b000};
    assign raw      = word >> {off, 3'b000};
    assign sign     = rstrb[8] & |(top & msb);

    genvar i;
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
        assign wmask[8*i +: 8] = {8{wlane[i]}};
        assign msb[i]          = raw[8*i+7];
        if (i == NUM_LANES-1) begin : g_top_last
            assign top[i] = rstrb[i];
        end else begin : g_top
            assign top[i] = rstrb[i] & ~rstrb[i+1];
        end
        assign rdata[8*i +: 8] = rstrb[i] ? raw[8*i +: 8] : {8{sign}};
    end

endmodule

// File: rtl/ysyx_22040750_dmem_resp.sv
// Data-memory responder: accepts one load/store per handshake and answers after a fixed
// latency. Define YSYX_22040750_DMEM_RANDLAT_EN to add 0..7 LFSR-driven extra wait cycles.
module ysyx_22040750_dmem_resp
    import ysyx_22040750_dmem_resp_pkg::*;
#(
    parameter int          AW      = 10,
    parameter logic [63:0] BASE    = DMEM_BASE_DEFAULT,
    parameter int          LATENCY = 2
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_mem_rd_en,
    input  logic        I_mem_wr_en,
    input  logic [63:0] I_mem_addr,
    input  logic [63:0] I_mem_wdata,
    input  logic [7:0]  I_wstrb,
    input  logic [8:0]  I_rstrb,
    output logic        O_mem_ready,
    output logic        O_mem_data_rvalid,
    output logic        O_mem_data_bvalid,
    output logic [63:0] O_mem_rdata
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;
    localparam int          CW    = 5;

    dmem_state_e   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] lat_cnt;
    dmem_req_t     req_q, req_cur;
    logic [63:0]   mem [DEPTH];
    logic [63:0]   rdata_q;
    logic          hs;

    logic [63:0]   rel;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [63:0]   wmask, wdata_sh, rd_ext;

    assign hs = (state == IDLE) & (I_mem_rd_en | I_mem_wr_en);

    // In IDLE the live request is used so the LATENCY=1 path can read without a latch stage.
    always_comb begin
        req_cur = req_q;
        if (state == IDLE) begin
            req_cur.op    = I_mem_wr_en ? OP_WR : OP_RD;
            req_cur.addr  = I_mem_addr;
            req_cur.wdata = I_mem_wdata;
            req_cur.wstrb = norm_strb(I_wstrb);
            req_cur.rstrb = {I_rstrb[8], norm_strb(I_rstrb[7:0])};
        end
    end

    assign rel      = req_cur.addr - BASE;
    assign in_range = rel < SPAN;
    assign idx      = rel[AW+2:3];

    ysyx_22040750_dmem_lane_align u_align (
        .off      (req_cur.addr[2:0]),
        .wdata    (req_cur.wdata),
        .wstrb    (req_cur.wstrb),
        .word     (mem[idx]),
        .rstrb    (req_cur.rstrb),
        .wmask    (wmask),
        .wdata_sh (wdata_sh),
        .rdata    (rd_ext)
    );

`ifdef YSYX_22040750_DMEM_RANDLAT_EN
    logic [15:0] lfsr;

    always_ff @(posedge I_sys_clk) begin
        if (I_rst)
            lfsr <= 16'hACE1;
        else if (hs)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign lat_cnt = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
    assign lat_cnt = CW'(LATENCY);
`endif

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            req_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= '0;
            if (hs)
                req_q <= req_cur;
            if (state_nxt == RESP && req_cur.op == OP_RD && in_range)
                rdata_q <= rd_ext;
        end
    end

    // cnt reaches 0 on the WAIT->RESP transition, so RESP lands exactly lat_cnt cycles after the handshake.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        O_mem_ready = 1'b0;
        case (state)
            IDLE: begin
                O_mem_ready = 1'b1;
                if (hs) begin
                    if (lat_cnt == CW'(1)) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = lat_cnt - CW'(1);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store contents survive reset; the commit is gated so an aborted write never lands.
    always_ff @(posedge I_sys_clk) begin
        if (!I_rst && state == RESP && req_q.op == OP_WR && in_range)
            mem[idx] <= (mem[idx] & ~wmask) | (wdata_sh & wmask);
    end

    assign O_mem_data_rvalid = (state == RESP) && (req_q.op == OP_RD);
    assign O_mem_data_bvalid = (state == RESP) && (req_q.op == OP_WR);
    assign O_mem_rdata       = rdata_q;

endmodule
